// File: rtl/mig_app_pkg.sv
// rtl/mig_app_pkg.sv - shared constants, MIG command codes and FSM state type
// Ports: none (package).
package mig_app_pkg;

    localparam int DEF_ADDR_W   = 30;
    localparam int DEF_DATA_W   = 256;
    localparam int DEF_RD_DEPTH = 4;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

endpackage

// File: rtl/mig_app_if.sv
// rtl/mig_app_if.sv - MIG user-interface (app_*) bundle
// Ports: none; signals app_en/app_cmd/app_addr/app_rdy (command), app_wdf_* (write data),
//        app_rd_data/app_rd_data_valid (read return). master = controller side, slave = MIG side.
interface mig_app_if
    import mig_app_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic                  app_en;
    logic [2:0]            app_cmd;
    logic [ADDR_W-1:0]     app_addr;
    logic                  app_rdy;
    logic                  app_wdf_wren;
    logic                  app_wdf_end;
    logic [DATA_W-1:0]     app_wdf_data;
    logic [DATA_W/8-1:0]   app_wdf_mask;
    logic                  app_wdf_rdy;
    logic [DATA_W-1:0]     app_rd_data;
    logic                  app_rd_data_valid;

    modport master (
        output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );

    modport slave (
        input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );

endinterface

// File: rtl/mig_rd_fifo.sv
// rtl/mig_rd_fifo.sv - read-response FIFO between MIG read return and the response port
// Ports: clk, rst_n (async active-low); push/push_data (no backpressure, caller guarantees space);
//        pop (consumer handshake); valid (registered non-empty), data (head entry).
module mig_rd_fifo #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_d;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign data    = mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (do_push && !do_pop) begin
            count_d = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count_d;
            // Valid is a flop so a push into an empty FIFO shows up one cycle later.
            valid <= (count_d != '0);
        end
    end

    // Storage needs no reset: an empty FIFO never exposes it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mig_app_master.sv
// rtl/mig_app_master.sv - single-beat request/response master for a MIG user interface
// Ports: ui_clk, ui_rst_n (async active-low); init_calib_complete;
//        req_valid/req_ready/req_we/req_addr/req_wdata/req_wmask (request in);
//        app (mig_app_if.master, MIG command/write/read-return bus);
//        rsp_valid/rsp_ready/rsp_data (read response out);
//        rd_outstanding, err_unexp_rd (sticky), busy (status).
module mig_app_master
    import mig_app_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RD_DEPTH = DEF_RD_DEPTH
) (
    input  logic                            ui_clk,
    input  logic                            ui_rst_n,
    input  logic                            init_calib_complete,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_we,
    input  logic [ADDR_W-1:0]               req_addr,
    input  logic [DATA_W-1:0]               req_wdata,
    input  logic [DATA_W/8-1:0]             req_wmask,
    mig_app_if.master                       app,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [DATA_W-1:0]               rsp_data,
    output logic [$clog2(RD_DEPTH):0]       rd_outstanding,
    output logic                            err_unexp_rd,
    output logic                            busy
);

    localparam int OW = $clog2(RD_DEPTH) + 1;

    state_t              state_q, state_d;
    logic                app_en_q, app_en_d;
    logic [2:0]          app_cmd_q, app_cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wren_q, wren_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W/8-1:0] mask_q, mask_d;
    logic [OW-1:0]       rd_out_q;
    logic [OW-1:0]       inflight_q;
    logic                err_q;

    logic req_fire;
    logic rd_issue;
    logic rsp_pop;
    logic rd_push;

    // Credit check bounds the FIFO: a read is only accepted if its response has a slot.
    assign req_ready = (state_q == IDLE) && init_calib_complete && (rd_out_q < OW'(RD_DEPTH));
    assign req_fire  = req_valid && req_ready;
    assign rd_issue  = req_fire && !req_we;
    assign rsp_pop   = rsp_valid && rsp_ready;
    // Read data is only legitimate while some read's data is still owed by the MIG.
    assign rd_push   = app.app_rd_data_valid && (inflight_q != '0);

    assign busy               = (state_q != IDLE);
    assign err_unexp_rd       = err_q;
    assign rd_outstanding     = rd_out_q;
    assign app.app_en         = app_en_q;
    assign app.app_cmd        = app_cmd_q;
    assign app.app_addr       = addr_q;
    assign app.app_wdf_wren   = wren_q;
    assign app.app_wdf_end    = wren_q;
    assign app.app_wdf_data   = data_q;
    assign app.app_wdf_mask   = mask_q;

    always_comb begin
        state_d   = state_q;
        app_en_d  = app_en_q;
        app_cmd_d = app_cmd_q;
        addr_d    = addr_q;
        wren_d    = wren_q;
        data_d    = data_q;
        mask_d    = mask_q;
        unique case (state_q)
            IDLE: begin
                if (req_fire) begin
                    addr_d   = req_addr;
                    data_d   = req_wdata;
                    mask_d   = req_wmask;
                    app_en_d = 1'b1;
                    if (req_we) begin
                        app_cmd_d = CMD_WRITE;
                        wren_d    = 1'b1;
                        state_d   = WR;
                    end else begin
                        app_cmd_d = CMD_READ;
                        state_d   = RD;
                    end
                end
            end
            WR: begin
                // Command and data channels retire independently, in either order.
                if (app.app_rdy)     app_en_d = 1'b0;
                if (app.app_wdf_rdy) wren_d   = 1'b0;
                if (!app_en_d && !wren_d) state_d = IDLE;
            end
            RD: begin
                if (app.app_rdy) begin
                    app_en_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ui_clk or negedge ui_rst_n) begin
        if (!ui_rst_n) begin
            state_q   <= IDLE;
            app_en_q  <= 1'b0;
            app_cmd_q <= '0;
            addr_q    <= '0;
            wren_q    <= 1'b0;
            data_q    <= '0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            app_en_q  <= app_en_d;
            app_cmd_q <= app_cmd_d;
            addr_q    <= addr_d;
            wren_q    <= wren_d;
            data_q    <= data_d;
            mask_q    <= mask_d;
        end
    end

    always_ff @(posedge ui_clk or negedge ui_rst_n) begin
        if (!ui_rst_n) begin
            rd_out_q   <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (rd_issue && !rsp_pop) begin
                rd_out_q <= rd_out_q + 1'b1;
            end else if (rsp_pop && !rd_issue) begin
                rd_out_q <= rd_out_q - 1'b1;
            end
            if (rd_issue && !rd_push) begin
                inflight_q <= inflight_q + 1'b1;
            end else if (rd_push && !rd_issue) begin
                inflight_q <= inflight_q - 1'b1;
            end
            if (app.app_rd_data_valid && (inflight_q == '0)) err_q <= 1'b1;
        end
    end

    mig_rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RD_DEPTH)
    ) u_rd_fifo (
        .clk       (ui_clk),
        .rst_n     (ui_rst_n),
        .push      (rd_push),
        .push_data (app.app_rd_data),
        .pop       (rsp_pop),
        .valid     (rsp_valid),
        .data      (rsp_data)
    );

endmodule

// File: tb/tb_mig_app_master.sv
// tb/tb_mig_app_master.sv - scoreboard bench for mig_app_master with a behavioural MIG model
module tb_mig_app_master;
    import mig_app_pkg::*;

    localparam int ADDR_W   = 30;
    localparam int DATA_W   = 64;
    localparam int RD_DEPTH = 4;
    localparam int MW       = DATA_W / 8;
    localparam int OW       = $clog2(RD_DEPTH) + 1;

    logic              ui_clk = 1'b0;
    logic              ui_rst_n = 1'b0;
    logic              init_calib_complete = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [MW-1:0]     req_wmask = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic [OW-1:0]     rd_outstanding;
    logic              err_unexp_rd;
    logic              busy;

    mig_app_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) app ();

    always #5 ui_clk = ~ui_clk;

    mig_app_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_DEPTH(RD_DEPTH)) dut (
        .ui_clk              (ui_clk),
        .ui_rst_n            (ui_rst_n),
        .init_calib_complete (init_calib_complete),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_we              (req_we),
        .req_addr            (req_addr),
        .req_wdata           (req_wdata),
        .req_wmask           (req_wmask),
        .app                 (app),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_data            (rsp_data),
        .rd_outstanding      (rd_outstanding),
        .err_unexp_rd        (err_unexp_rd),
        .busy                (busy)
    );

    typedef struct {
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [MW-1:0]     mask;
    } req_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } rd_t;

    req_t              cmd_q[$];
    logic [DATA_W-1:0] rsp_exp_q[$];
    rd_t               rd_pipe[$];
    logic [DATA_W-1:0] ref_mem[16];
    logic [DATA_W-1:0] ref_save[16];
    logic [DATA_W-1:0] mig_mem[16];

    int tests = 0, fails = 0, cyc = 0;
    int pend = 0, rd_out_exp = 0, fifo_exp = 0;
    bit err_exp = 0, chk_en = 0, inject_unexp = 0;
    int rdy_prob = 100, wdf_prob = 100, rsp_prob = 100, en_delay = 0, lat_min = 1, lat_max = 1;
    int cnt_en = 0, cnt_wren = 0;
    bit req_hs_now = 0;
    req_t req_hs;
    bit wr_cmd_seen = 0, wr_dat_seen = 0;
    req_t cur_wr;
    logic [ADDR_W-1:0] wr_a;
    logic [DATA_W-1:0] wr_d;
    logic [MW-1:0]     wr_m;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old, input logic [DATA_W-1:0] nw,
                                                input logic [MW-1:0] m);
        logic [DATA_W-1:0] r;
        r = old;
        for (int b = 0; b < MW; b++) if (!m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
    endtask

    // MIG model + monitor: drives MIG/response inputs at negedge, samples 2 ns later.
    always @(negedge ui_clk) begin
        req_t e;
        bit   rdv_drv, rdv_push;
        if (en_delay > 0 && app.app_en) begin
            app.app_rdy = 1'b0;
            en_delay--;
        end else begin
            app.app_rdy = ($urandom_range(99) < rdy_prob);
        end
        app.app_wdf_rdy = ($urandom_range(99) < wdf_prob);
        rsp_ready = ($urandom_range(99) < rsp_prob);
        rdv_drv = 0;
        rdv_push = 0;
        if (inject_unexp) begin
            rdv_drv = 1;
            app.app_rd_data = {$urandom, $urandom};
            inject_unexp = 0;
        end else if (rd_pipe.size() > 0 && rd_pipe[0].due <= cyc) begin
            rdv_drv = 1;
            rdv_push = 1;
            app.app_rd_data = rd_pipe[0].data;
            void'(rd_pipe.pop_front());
        end
        app.app_rd_data_valid = rdv_drv;
        #2;
        if (chk_en) begin
            check("busy", busy, pend > 0);
            check("req_ready", req_ready, (pend == 0) && init_calib_complete && (rd_out_exp < RD_DEPTH));
            check("rd_outstanding", rd_outstanding, rd_out_exp);
            check("rsp_valid", rsp_valid, fifo_exp > 0);
            check("err_unexp_rd", err_unexp_rd, err_exp);
            if (app.app_en) cnt_en++;
            if (app.app_wdf_wren) cnt_wren++;
            if (app.app_en && app.app_rdy) begin
                if (cmd_q.size() == 0) begin
                    fail_now("unexpected_app_cmd");
                end else begin
                    e = cmd_q.pop_front();
                    check("app_cmd", app.app_cmd, e.we ? CMD_WRITE : CMD_READ);
                    check("app_addr", app.app_addr, e.addr);
                    pend--;
                    if (e.we) begin
                        cur_wr = e;
                        wr_cmd_seen = 1;
                        wr_a = app.app_addr;
                    end else begin
                        rd_pipe.push_back('{mig_mem[app.app_addr[7:4]], cyc + int'($urandom_range(lat_max, lat_min))});
                    end
                end
            end
            if (app.app_wdf_wren && app.app_wdf_rdy) begin
                if (wr_cmd_seen) e = cur_wr;
                else if (cmd_q.size() > 0) e = cmd_q[0];
                else e = '{we: 1'b0, addr: '0, data: '0, mask: '0};
                check("app_wdf_data", app.app_wdf_data, e.data);
                check("app_wdf_mask", app.app_wdf_mask, e.mask);
                check("app_wdf_end", app.app_wdf_end, 1'b1);
                wr_d = app.app_wdf_data;
                wr_m = app.app_wdf_mask;
                wr_dat_seen = 1;
                pend--;
            end
            if (wr_cmd_seen && wr_dat_seen) begin
                mig_mem[wr_a[7:4]] = merge(mig_mem[wr_a[7:4]], wr_d, wr_m);
                wr_cmd_seen = 0;
                wr_dat_seen = 0;
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_exp_q.size() == 0) fail_now("unexpected_rsp");
                else check("rsp_data", rsp_data, rsp_exp_q.pop_front());
                rd_out_exp--;
                fifo_exp--;
            end
            if (rdv_drv && !rdv_push) err_exp = 1;
            if (rdv_push) fifo_exp++;
            if (req_hs_now) begin
                req_hs_now = 0;
                cmd_q.push_back(req_hs);
                if (req_hs.we) begin
                    ref_mem[req_hs.addr[7:4]] = merge(ref_mem[req_hs.addr[7:4]], req_hs.data, req_hs.mask);
                    pend = 2;
                end else begin
                    rsp_exp_q.push_back(ref_mem[req_hs.addr[7:4]]);
                    pend = 1;
                    rd_out_exp++;
                end
            end
        end
        cyc++;
    end

    task automatic issue(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic [MW-1:0] m);
        int n;
        n = 0;
        @(negedge ui_clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        #1;
        while (!req_ready && n < 500) begin
            @(negedge ui_clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            fail_now("req_accept_timeout");
        end else begin
            req_hs.we   = we;
            req_hs.addr = a;
            req_hs.data = d;
            req_hs.mask = m;
            req_hs_now  = 1;
        end
        @(posedge ui_clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((pend != 0 || cmd_q.size() != 0 || rd_pipe.size() != 0 || rsp_exp_q.size() != 0) && n < 1000) begin
            @(negedge ui_clk);
            #3;
            n++;
        end
        if (n >= 1000) fail_now(name);
        @(negedge ui_clk);
        #3;
    endtask

    task automatic clear_model();
        cmd_q.delete();
        rsp_exp_q.delete();
        rd_pipe.delete();
        pend = 0;
        rd_out_exp = 0;
        fifo_exp = 0;
        err_exp = 0;
        req_hs_now = 0;
        wr_cmd_seen = 0;
        wr_dat_seen = 0;
        en_delay = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, w0, n;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = '0;
            mig_mem[i] = '0;
        end
        app.app_rdy = 1'b0;
        app.app_wdf_rdy = 1'b0;
        app.app_rd_data = '0;
        app.app_rd_data_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge ui_clk);
        #3;
        check("rst_app_en", app.app_en, 1'b0);
        check("rst_app_wdf_wren", app.app_wdf_wren, 1'b0);
        check("rst_app_wdf_end", app.app_wdf_end, 1'b0);
        check("rst_app_cmd", app.app_cmd, 3'b000);
        check("rst_app_addr", app.app_addr, 0);
        check("rst_app_wdf_data", app.app_wdf_data, 0);
        check("rst_app_wdf_mask", app.app_wdf_mask, 0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err_unexp_rd, 1'b0);
        check("rst_rd_outstanding", rd_outstanding, 0);
        check("rst_req_ready_nocal", req_ready, 1'b0);
        @(negedge ui_clk);
        ui_rst_n = 1'b1;
        init_calib_complete = 1'b1;
        chk_en = 1;

        // Single write, MIG always ready
        e0 = cnt_en;
        w0 = cnt_wren;
        issue(1'b1, 30'h10, 64'hA5, '0);
        wait_idle("wr_basic_idle");
        check("wr_basic_en_cycles", cnt_en - e0, 1);
        check("wr_basic_wren_cycles", cnt_wren - w0, 1);
        check("wr_basic_busy", busy, 1'b0);

        // Write with app_rdy held low for 3 cycles
        e0 = cnt_en;
        w0 = cnt_wren;
        en_delay = 3;
        issue(1'b1, 30'h20, 64'h1234_5678_9ABC_DEF0, 8'h00);
        wait_idle("wr_stall_idle");
        check("wr_stall_en_cycles", cnt_en - e0, 4);
        check("wr_stall_wren_cycles", cnt_wren - w0, 1);

        // Write then read back, 1-cycle read latency
        issue(1'b1, 30'h10, 64'hA5, '0);
        issue(1'b0, 30'h10, '0, '0);
        wait_idle("wr_rd_idle");

        // Credit limit: four reads fill the FIFO, the fifth waits for a pop
        rsp_prob = 0;
        for (int i = 0; i < 4; i++) issue(1'b0, ADDR_W'((i + 1) << 4), '0, '0);
        fork
            issue(1'b0, 30'h50, '0, '0);
            begin
                repeat (10) @(negedge ui_clk);
                #3;
                check("credit_rd_outstanding", rd_outstanding, 4);
                check("credit_req_ready", req_ready, 1'b0);
                rsp_prob = 100;
            end
        join
        wait_idle("credit_idle");

        // Reset mid-write with an undelivered read response held in the FIFO
        rsp_prob = 0;
        issue(1'b0, 30'h10, '0, '0);
        n = 0;
        while ((fifo_exp == 0) && n < 50) begin
            @(negedge ui_clk);
            n++;
        end
        ref_save = ref_mem;
        rdy_prob = 0;
        issue(1'b1, 30'h30, 64'hDEAD_BEEF, '0);
        repeat (2) @(negedge ui_clk);
        #3;
        ui_rst_n = 1'b0;
        chk_en = 0;
        #1;
        check("rstmid_app_en", app.app_en, 1'b0);
        check("rstmid_wren", app.app_wdf_wren, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_rd_outstanding", rd_outstanding, 0);
        check("rstmid_rsp_valid", rsp_valid, 1'b0);
        clear_model();
        ref_mem = ref_save;
        rdy_prob = 100;
        rsp_prob = 100;
        @(negedge ui_clk);
        ui_rst_n = 1'b1;
        chk_en = 1;
        repeat (2) @(negedge ui_clk);

        // Read data with no read in flight
        inject_unexp = 1;
        repeat (3) @(negedge ui_clk);
        #3;
        check("unexp_err", err_unexp_rd, 1'b1);
        check("unexp_rsp_valid", rsp_valid, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            if (i % 25 == 0) begin
                rdy_prob = $urandom_range(100, 30);
                wdf_prob = $urandom_range(100, 30);
                rsp_prob = $urandom_range(100, 20);
                lat_min  = 1;
                lat_max  = $urandom_range(4, 1);
            end
            issue($urandom_range(1), ADDR_W'($urandom_range(15) << 4), {$urandom, $urandom},
                  ($urandom_range(1) != 0) ? MW'($urandom) : '0);
            if ($urandom_range(3) == 0) begin
                init_calib_complete = 1'b0;
                repeat (2) @(negedge ui_clk);
                init_calib_complete = 1'b1;
            end
        end
        rsp_prob = 100;
        rdy_prob = 100;
        wdf_prob = 100;
        wait_idle("drain_idle");
        check("drain_cmd_q", cmd_q.size(), 0);
        check("drain_rsp_q", rsp_exp_q.size(), 0);
        check("drain_rd_outstanding", rd_outstanding, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mig_app_master.md
MIG_APP_MASTER -- requirements
Module: mig_app_master

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all state SHALL clear immediately on reset assertion.
REQ-002 SHALL declare parameters as name, default, meaning:
- ADDR_W, 30, app address width
- DATA_W, 256, data width
- RD_DEPTH, 4, read-response FIFO depth and read credit limit
REQ-003 SHALL declare ports as name, direction, width, meaning:
- ui_clk, in, 1, clock
- ui_rst_n, in, 1, async active-low reset
- init_calib_complete, in, 1, MIG ready
- req_valid, in, 1, request valid
- req_ready, out, 1, request ready
- req_we, in, 1, 1=write, 0=read
- req_addr, in, ADDR_W, address
- req_wdata, in, DATA_W, write data
- req_wmask, in, DATA_W/8, byte mask (1 = masked)
- app_en, out, 1, MIG command valid
- app_cmd, out, 3, MIG command
- app_addr, out, ADDR_W, MIG address
- app_rdy, in, 1, MIG command ready
- app_wdf_wren, out, 1, write data valid
- app_wdf_end, out, 1, last write beat
- app_wdf_data, out, DATA_W, write data
- app_wdf_mask, out, DATA_W/8, write mask
- app_wdf_rdy, in, 1, write data ready
- app_rd_data, in, DATA_W, read data
- app_rd_data_valid, in, 1, read data valid
- rsp_valid, out, 1, read response valid
- rsp_ready, in, 1, read response ready
- rsp_data, out, DATA_W, read response data
- rd_outstanding, out, $clog2(RD_DEPTH)+1, reads issued but not yet popped
- err_unexp_rd, out, 1, sticky: read data arrived with no read in flight
- busy, out, 1, FSM not in IDLE

Function
REQ-004 SHALL use FSM states IDLE, WR, RD; all outputs registered.
REQ-005 req_ready SHALL be (state==IDLE) & init_calib_complete & (rd_outstanding<RD_DEPTH); it SHALL NOT depend on req_valid or req_we.
REQ-006 On req handshake in IDLE, SHALL latch addr, data and mask, and go to WR (req_we=1) or RD (req_we=0). app_en SHALL assert on the next cycle.
REQ-007 WR: SHALL drive app_cmd=000 with app_en, app_wdf_wren and app_wdf_end all high. app_en SHALL drop after app_en&app_rdy. app_wdf_wren/end SHALL drop after app_wdf_wren&app_wdf_rdy. The two handshakes MAY complete in either order or the same cycle. SHALL return to IDLE the cycle after both complete.
REQ-008 RD: SHALL drive app_cmd=001 with app_en high until app_en&app_rdy, then return to IDLE.
REQ-009 app_addr SHALL pass through unmodified. The write is one beat per command (app_wdf_end==app_wdf_wren).
REQ-010 rd_outstanding SHALL increment on a read req handshake and decrement on rsp_valid&rsp_ready. When both occur in the same cycle it SHALL be unchanged.
REQ-011 app_rd_data_valid SHALL push app_rd_data into the FIFO without backpressure. The credit rule in REQ-005 guarantees no overflow.
REQ-012 rsp_valid SHALL assert the cycle after the push into an empty FIFO. Order SHALL be FIFO order. rsp_data SHALL hold stable while rsp_valid&!rsp_ready.
REQ-013 app_rd_data_valid while (reads in flight)==0 SHALL be dropped and SHALL set err_unexp_rd; only reset clears it.
REQ-014 If init_calib_complete falls mid-transaction, the current transaction SHALL complete; only new acceptance is blocked.

Reset
REQ-015 Reset values: app_en, app_wdf_wren, app_wdf_end, rsp_valid, busy, err_unexp_rd = 0; app_cmd, app_addr, app_wdf_data, app_wdf_mask = 0; rd_outstanding = 0; FIFO empty; state IDLE.
REQ-016 Reset mid-transaction SHALL abandon the transaction immediately with no further app_en. Late MIG read data is then handled per REQ-013.

Structure
REQ-017 Package mig_app_pkg SHALL hold CMD_WRITE=3'b000, CMD_READ=3'b001, the state enum and the default widths.
REQ-018 The read FIFO SHALL be the sub-module mig_rd_fifo, with parameters DATA_W and DEPTH and async active-low reset.

Verification
REQ-019 Write addr 0x10, data 0xA5 with app_rdy and app_wdf_rdy high -> app_en and app_wdf_wren high for exactly 1 cycle each, app_cmd=000, busy returns to 0.
REQ-020 Write with app_rdy low for 3 cycles and app_wdf_rdy high -> data accepted cycle 1, app_en held 4 cycles, req_ready low until both handshakes are done.
REQ-021 Write 0x10=0xA5, then read 0x10, with 1-cycle MIG read latency -> rsp_valid with rsp_data=0xA5 on the cycle after app_rd_data_valid.
REQ-022 Five back-to-back reads with rsp_ready=0 -> four accepted, req_ready low with rd_outstanding=4. Set rsp_ready=1 -> responses pop in order and the fifth read is accepted.
REQ-023 Pulse app_rd_data_valid with no read issued -> err_unexp_rd=1 and rsp_valid stays 0.
REQ-024 Assert ui_rst_n=0 during WR with app_rdy low -> app_en=0 immediately, rd_outstanding=0, state IDLE.
